// File: rtl/aes_decipher_core_p.sv
// AES inverse-cipher round engine. One 128-bit block per transaction, 128/192/256-bit keys,
// round keys fetched from an external key memory addressed by round_number. NUM_SBOX inverse
// S-box words are evaluated per cycle, trading area for throughput.
module aes_decipher_core_p #(
    parameter int unsigned NUM_SBOX = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   keylen,
    input  logic [127:0] block,
    output logic [3:0]   round_number,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] new_block,
    output logic         busy
);

    generate
        if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
            $fatal(1, "aes_decipher_core_p: NUM_SBOX must be 1, 2 or 4");
        end
    endgenerate

    localparam int unsigned SPASS      = 4 / NUM_SBOX;
    localparam logic [1:0]  LAST_GROUP = 2'(SPASS - 1);

    typedef enum logic [2:0] {StIdle, StInit, StSbox, StMain, StDone} state_t;

    state_t         state_q;
    logic [3:0]     round_ctr_q;
    logic [1:0]     sword_ctr_q;
    logic [127:0]   st_q;

    // GF(2^8) multiply, reduction polynomial 0x11b.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
        return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
    endfunction

    // Row r of the state rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[127 - 32*c - 8*rr -: 8] = s[127 - 32*((c - rr + 4) % 4) - 8*rr -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
    endfunction

    function automatic logic [3:0] num_rounds(input logic [1:0] kl);
        case (kl)
            2'b01:   return 4'd12;
            2'b10:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    logic [127:0] st_xk;
    logic [31:0]  words     [4];
    logic [31:0]  sub_words [4];
    logic [1:0]   grp_idx;
    logic [127:0] st_sbox;

    assign st_xk = st_q ^ round_key;

    // Split the state into column words for the S-box group mux.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            words[c] = st_q[127 - 32*c -: 32];
        end
    end

    // Only the NUM_SBOX words of the current group pass through the inverse S-boxes.
    always_comb begin
        sub_words = words;
        grp_idx   = '0;
        for (int g = 0; g < int'(NUM_SBOX); g++) begin
            grp_idx            = 2'(int'(sword_ctr_q) * int'(NUM_SBOX) + g);
            sub_words[grp_idx] = inv_sub_word(words[grp_idx]);
        end
    end

    assign st_sbox      = {sub_words[0], sub_words[1], sub_words[2], sub_words[3]};
    assign new_block    = st_q;
    assign round_number = round_ctr_q;

    // Round sequencing FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            round_ctr_q <= 4'd0;
            sword_ctr_q <= 2'd0;
            st_q        <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        st_q        <= block;
                        round_ctr_q <= num_rounds(keylen);
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state_q     <= StInit;
                    end
                end
                StInit: begin
                    st_q        <= inv_shift_rows(st_xk);
                    round_ctr_q <= round_ctr_q - 4'd1;
                    sword_ctr_q <= 2'd0;
                    state_q     <= StSbox;
                end
                StSbox: begin
                    st_q <= st_sbox;
                    if (sword_ctr_q == LAST_GROUP) begin
                        sword_ctr_q <= 2'd0;
                        state_q     <= StMain;
                    end else begin
                        sword_ctr_q <= sword_ctr_q + 2'd1;
                    end
                end
                StMain: begin
                    if (round_ctr_q != 4'd0) begin
                        st_q        <= inv_shift_rows(inv_mix_columns(st_xk));
                        round_ctr_q <= round_ctr_q - 4'd1;
                        state_q     <= StSbox;
                    end else begin
                        st_q      <= st_xk;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decipher_core_p.sv
// Scoreboard bench for aes_decipher_core_p: three instances (NUM_SBOX 1, 2, 4) share a
// key memory built by a local key-expansion model; expected plaintexts are FIPS-197 vectors.
module tb_aes_decipher_core_p;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic         in_valid     [3];
    logic         in_ready     [3];
    logic         out_valid    [3];
    logic         out_ready    [3];
    logic         busy         [3];
    logic [3:0]   round_number [3];
    logic [127:0] round_key    [3];
    logic [127:0] new_block    [3];
    logic [127:0] rk_mem       [16];

    always #5 clk = ~clk;

    assign round_key[0] = rk_mem[round_number[0]];
    assign round_key[1] = rk_mem[round_number[1]];
    assign round_key[2] = rk_mem[round_number[2]];

    aes_decipher_core_p #(.NUM_SBOX(1)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .keylen(keylen), .block(block), .round_number(round_number[0]),
        .round_key(round_key[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .new_block(new_block[0]), .busy(busy[0])
    );
    aes_decipher_core_p #(.NUM_SBOX(2)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .keylen(keylen), .block(block), .round_number(round_number[1]),
        .round_key(round_key[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .new_block(new_block[1]), .busy(busy[1])
    );
    aes_decipher_core_p #(.NUM_SBOX(4)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .keylen(keylen), .block(block), .round_number(round_number[2]),
        .round_key(round_key[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .new_block(new_block[2]), .busy(busy[2])
    );

    typedef struct {
        logic [127:0] data;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb_q [3][$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   act_on   [3];
    int   act_a    [3];
    int   act_nr   [3];
    int   act_s    [3];
    int   rise_cyc [3];
    int   hs_cyc   [3];
    int   last_acc [3];
    bit   prev_ov  [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic int s_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 1;
    endfunction

    // Forward S-box for the key schedule model.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] b;
        sq = x;
        b  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            b  = gmul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
    endfunction

    // Key bytes are 00,01,02,... for nk 32-bit words.
    task automatic load_keys(input int nk);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) begin
            w[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
        end
        for (int i = nk; i < 4*(nr + 1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 16; r++) begin
            rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
        end
    endtask

    // Presents one block; pushes the expectation at the edge where it will be accepted.
    task automatic send(input int i, input logic [1:0] kl, input logic [127:0] ct);
        int   n;
        int   nr;
        exp_t e;
        n  = 0;
        nr = (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 10;
        @(posedge clk); #1;
        keylen      = kl;
        block       = ct;
        in_valid[i] = 1'b1;
        while (!in_ready[i] && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready[i]) begin
            chk($sformatf("accept_timeout[%0d]", i), 128'(0), 128'(1));
            in_valid[i] = 1'b0;
            return;
        end
        e.data = PT;
        e.acc  = cyc + 1;
        e.lat  = 1 + nr * (s_of(i) + 1);
        sb_q[i].push_back(e);
        act_on[i]   = 1'b1;
        act_a[i]    = cyc + 1;
        act_nr[i]   = nr;
        act_s[i]    = s_of(i);
        last_acc[i] = cyc + 1;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        // Inputs changing after accept must not disturb the running block.
        block  = ~ct;
        keylen = ~kl;
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while (sb_q[i].size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("drain[%0d]", i), 128'(sb_q[i].size()), 128'(0));
    endtask

    // Monitor: round-index model every cycle, result/latency check on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        int   exp_rn;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                exp_rn = 0;
                if (act_on[i] && cyc >= act_a[i] &&
                    cyc < act_a[i] + 1 + act_nr[i] * (act_s[i] + 1)) begin
                    if (cyc == act_a[i]) exp_rn = act_nr[i];
                    else exp_rn = act_nr[i] - 1 - (cyc - act_a[i] - 1) / (act_s[i] + 1);
                end
                chk($sformatf("round_number[%0d]@%0d", i, cyc), 128'(round_number[i]),
                    128'(exp_rn));
                if (out_valid[i] && !prev_ov[i]) rise_cyc[i] = cyc;
                if (out_valid[i] && out_ready[i]) begin
                    if (sb_q[i].size() == 0) begin
                        chk($sformatf("unexpected_output[%0d]", i), 128'(1), 128'(0));
                    end else begin
                        e = sb_q[i].pop_front();
                        chk($sformatf("new_block[%0d]", i), new_block[i], e.data);
                        chk($sformatf("latency[%0d]", i), 128'(rise_cyc[i] - e.acc),
                            128'(e.lat));
                    end
                    hs_cyc[i] = cyc + 1;
                end
                prev_ov[i] = out_valid[i];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset  = 1'b1;
        keylen = 2'b00;
        block  = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            act_on[i]    = 1'b0;
            prev_ov[i]   = 1'b0;
            rise_cyc[i]  = 0;
            hs_cyc[i]    = 0;
            last_acc[i]  = 0;
        end
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_in_ready[%0d]", i), 128'(in_ready[i]), 128'(1));
            chk($sformatf("rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
            chk($sformatf("rst_busy[%0d]", i), 128'(busy[i]), 128'(0));
            chk($sformatf("rst_round_number[%0d]", i), 128'(round_number[i]), 128'(0));
            chk($sformatf("rst_new_block[%0d]", i), new_block[i], 128'(0));
        end
        reset = 1'b0;

        // AES-128, then keylen 11 behaving as 128.
        load_keys(4);
        send(0, 2'b00, C128);
        drain(0);
        send(0, 2'b11, C128);
        drain(0);

        // AES-192.
        load_keys(6);
        send(0, 2'b01, C192);
        drain(0);

        // AES-256 on all three S-box widths.
        load_keys(8);
        send(0, 2'b10, C256);
        drain(0);
        send(1, 2'b10, C256);
        drain(1);
        send(2, 2'b10, C256);
        drain(2);

        // Back-pressure: result held in DONE while a second block waits.
        load_keys(4);
        out_ready[0] = 1'b0;
        send(0, 2'b00, C128);
        n = 0;
        while (!out_valid[0] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_out_valid_seen", 128'(out_valid[0]), 128'(1));
        fork
            send(0, 2'b00, C128);
            begin
                repeat (20) begin
                    @(negedge clk);
                    chk("hold_new_block", new_block[0], PT);
                    chk("hold_in_ready", 128'(in_ready[0]), 128'(0));
                    chk("hold_out_valid", 128'(out_valid[0]), 128'(1));
                    chk("hold_busy", 128'(busy[0]), 128'(1));
                end
                @(posedge clk); #1;
                out_ready[0] = 1'b1;
            end
        join
        chk("second_accept_cycle", 128'(last_acc[0]), 128'(hs_cyc[0] + 1));
        drain(0);

        // Reset 25 cycles into a block, then a fresh block.
        send(0, 2'b00, C128);
        repeat (24) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
        chk("mid_rst_new_block", new_block[0], 128'(0));
        chk("mid_rst_round_number", 128'(round_number[0]), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
        chk("mid_rst_busy", 128'(busy[0]), 128'(0));
        for (int i = 0; i < 3; i++) begin
            act_on[i] = 1'b0;
            sb_q[i].delete();
        end
        reset = 1'b0;
        send(0, 2'b00, C128);
        drain(0);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("final_queue_empty[%0d]", i), 128'(sb_q[i].size()), 128'(0));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
